hex_keypad_scanner: RTL and testbench
=====================================

Name: hex_keypad_scanner

Overview:
- Input-side counterpart of the seven-segment display driver: scans a 4x4 hex keypad, debounces it and hands key codes to the CPU side.
- The display driver multiplexes digit strobes out to show a bus value. This block multiplexes column strobes out and reads rows back to build a bus value.
- Sits between the board keypad pins and the 8-bit system bus / input register.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven low (column dwell time); minimum 4.
DEBOUNCE_SCANS, 4, consecutive identical full scan frames needed to accept a press or a release; minimum 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
row_i  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
col_o  output  4  keypad column strobes, active-low one-hot.
key_o  output  4  last accepted key code.
key_valid_o  output  1  new key available; held until ack.
ack_i  input  1  consumer acknowledge for key_valid_o.
overrun_o  output  1  sticky: a press was dropped while key_valid_o was pending.
bus_o  output  8  two-digit entry register; each accepted key shifts in as the low nibble.
clear_i  input  1  synchronous clear of bus_o.

Behaviour:
- Reset (async, rst_n low):
  - col_o=4'b1110 (column 0), key_o=0, key_valid_o=0, overrun_o=0, bus_o=0.
  - Scan counters = 0. FSM = IDLE. Synchronizer flops = 4'b1111.
- row_i passes through a 2-flop synchronizer before any use.
- Column scan:
  - col_o cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Each column is held for exactly SCAN_DIV cycles.
  - A frame is 4*SCAN_DIV cycles.
- Row sampling:
  - Synchronized rows are sampled on the last cycle of each column dwell (cycle SCAN_DIV-1).
  - This allows at least SCAN_DIV-3 settle cycles.
- Key code: key = {row_idx[1:0], col_idx[1:0]}, where row_idx is the index of the low row bit.
- Frame result, evaluated at the end of column 3:
  - NONE if no row was low in any column.
  - KEY(k) if exactly one row/column intersection was low.
  - MULTI if more than one intersection was low. MULTI is treated as NONE for acceptance but resets the press candidate.
- FSM, evaluated once per frame end:
  - IDLE: KEY(k) -> latch candidate k, count=1, go to CANDIDATE.
  - CANDIDATE:
    - Same k -> count+1.
    - Different key, NONE or MULTI -> back to IDLE.
    - When count reaches DEBOUNCE_SCANS -> ACCEPT (one clock).
  - ACCEPT -> PRESSED. Accept actions:
    - If key_valid_o=0: key_o<=k, key_valid_o<=1.
    - If key_valid_o=1 and ack_i=0: key_o unchanged, overrun_o<=1.
    - bus_o<={bus_o[3:0],k} in both cases.
  - PRESSED: need DEBOUNCE_SCANS consecutive NONE frames -> IDLE. Any KEY or MULTI frame restarts the release count.
  - No auto-repeat: a held key produces exactly one acceptance.
- Handshake:
  - key_valid_o clears on the clock where ack_i=1; overrun_o clears on the same clock.
  - ack_i in the same cycle as ACCEPT: the new key is taken (key_o<=k, key_valid_o stays 1), no overrun.
  - ack_i while key_valid_o=0 is ignored.
- clear_i:
  - bus_o<=0 next clock.
  - If coincident with ACCEPT, the result is {4'h0,k}; clear is applied first, then the shift.
- Latency: key_valid_o rises 1 clock after the frame-end edge on which the count reaches DEBOUNCE_SCANS.
- Reset mid-scan or mid-debounce: immediate return to the reset state; a key held through reset is re-debounced from IDLE.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_SCANS=2 (frame = 16 cycles) for all scenarios.
1. Reset and scan order:
   - Release rst_n, no keys pressed.
   - col_o is 1110,1101,1011,0111 for 4 cycles each and repeats.
   - All outputs stay 0; key_valid_o is never asserted.
2. Single press and ack:
   - Hold row1 low while col2 is strobed (key 6) for 4 frames.
   - key_o=4'h6 and key_valid_o=1 one clock after the 2nd frame end; bus_o=8'h06.
   - Exactly one acceptance while held.
   - Pulse ack_i -> key_valid_o=0.
3. Two-digit entry and clear:
   - Press/release key A (row2,col2), then key B (row2,col3), with no ack.
   - Result: bus_o=8'hAB, key_o=4'hA, overrun_o=1.
   - ack_i clears key_valid_o and overrun_o.
   - clear_i gives bus_o=0.
4. Bounce rejection:
   - Toggle key 3 present/absent on alternating frames for 6 frames.
   - No acceptance; key_valid_o stays 0; bus_o unchanged.
5. Ghost/multi:
   - Press keys 0 and 5 together for 4 frames -> no acceptance.
   - Release key 5 -> key 0 accepted after 2 frames.
6. Async reset mid-debounce:
   - Assert rst_n low between the 1st and 2nd qualifying frames of key F.
   - Outputs return to reset values immediately.
   - After release, with F still held, acceptance needs 2 full new frames.

Source files
------------

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: drives active-low column strobes, samples synchronized rows,
// debounces whole scan frames and delivers key codes with a valid/ack handshake plus a two-digit entry register.
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  input  logic       ack_i,
  output logic       overrun_o,
  output logic [7:0] bus_o,
  input  logic       clear_i
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {IDLE, CANDIDATE, ACCEPT, PRESSED} state_t;

  logic [3:0]    row_meta_reg, row_sync_reg;
  logic [DW-1:0] dwell_reg;
  logic [1:0]    col_idx_reg;
  logic [1:0]    hits_reg;
  logic [3:0]    hit_key_reg;
  state_t        state_reg, state_next;
  logic [3:0]    cand_reg, cand_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic       col_end, frame_end, accept;
  logic [3:0] row_low;
  logic [2:0] row_hits;
  logic [1:0] row_idx;
  logic [1:0] hits_now;
  logic [3:0] key_now;
  logic       frame_single;

  assign col_o     = ~(4'b0001 << col_idx_reg);
  assign col_end   = (dwell_reg == DWELL_LAST);
  assign frame_end = col_end && (col_idx_reg == 2'd3);
  assign row_low   = ~row_sync_reg;
  assign accept    = (state_reg == ACCEPT);

  // Count low rows in the current column; descending loop leaves the lowest index.
  always_comb begin
    row_hits = 3'd0;
    row_idx  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_low[r]) begin
        row_hits = row_hits + 3'd1;
        row_idx  = r[1:0];
      end
    end
  end

  // Frame accumulator: 0 = none, 1 = single intersection, 2 = multiple.
  always_comb begin
    hits_now = hits_reg;
    key_now  = hit_key_reg;
    if (row_hits == 3'd1 && hits_reg == 2'd0) begin
      hits_now = 2'd1;
      key_now  = {row_idx, col_idx_reg};
    end else if (row_hits != 3'd0) begin
      hits_now = 2'd2;
    end
  end

  assign frame_single = (hits_now == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_reg <= 4'b1111;
      row_sync_reg <= 4'b1111;
      dwell_reg    <= '0;
      col_idx_reg  <= 2'd0;
      hits_reg     <= 2'd0;
      hit_key_reg  <= 4'd0;
    end else begin
      row_meta_reg <= row_i;
      row_sync_reg <= row_meta_reg;
      if (col_end) begin
        dwell_reg   <= '0;
        col_idx_reg <= col_idx_reg + 2'd1;
        if (frame_end) begin
          hits_reg    <= 2'd0;
          hit_key_reg <= 4'd0;
        end else begin
          hits_reg    <= hits_now;
          hit_key_reg <= key_now;
        end
      end else begin
        dwell_reg <= dwell_reg + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cand_reg  <= 4'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (frame_end && frame_single) begin
          cand_next  = key_now;
          cnt_next   = CNT_ONE;
          state_next = (DB_TARGET == CNT_ONE) ? ACCEPT : CANDIDATE;
        end
      end
      CANDIDATE: begin
        if (frame_end) begin
          if (frame_single && key_now == cand_reg) begin
            cnt_next = cnt_reg + CNT_ONE;
            if (cnt_reg + CNT_ONE == DB_TARGET) state_next = ACCEPT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      ACCEPT: begin
        state_next = PRESSED;
        cnt_next   = '0;
      end
      PRESSED: begin
        // Any key activity restarts the release count.
        if (frame_end) begin
          if (hits_now == 2'd0) begin
            if (cnt_reg + CNT_ONE == DB_TARGET) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end else begin
            cnt_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_o       <= 4'd0;
      key_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
      bus_o       <= 8'd0;
    end else begin
      if (accept) begin
        if (!key_valid_o || ack_i) begin
          key_o       <= cand_reg;
          key_valid_o <= 1'b1;
          overrun_o   <= 1'b0;
        end else begin
          overrun_o <= 1'b1;
        end
        // Clear takes effect before the new digit shifts in.
        bus_o <= {(clear_i ? 4'h0 : bus_o[3:0]), cand_reg};
      end else begin
        if (ack_i) begin
          key_valid_o <= 1'b0;
          overrun_o   <= 1'b0;
        end
        if (clear_i) bus_o <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with a behavioural 4x4 keypad (SCAN_DIV=4, DEBOUNCE_SCANS=2).
module tb_hex_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_o;
  logic       key_valid_o;
  logic       ack_i;
  logic       overrun_o;
  logic [7:0] bus_o;
  logic       clear_i;

  logic [15:0] pressed;
  logic [3:0]  exp_col;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst_n(rst_n), .row_i(row_i), .col_o(col_o), .key_o(key_o),
    .key_valid_o(key_valid_o), .ack_i(ack_i), .overrun_o(overrun_o),
    .bus_o(bus_o), .clear_i(clear_i)
  );

  // Key index = row*4 + col; a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    rst_n = 1'b0; ack_i = 1'b0; clear_i = 1'b0; pressed = 16'h0;
    tick(3);
    chk("rst_col", {4'h0, col_o}, 8'h0E);
    chk("rst_key", {4'h0, key_o}, 8'h00);
    chk("rst_valid", {7'h0, key_valid_o}, 8'h00);
    chk("rst_overrun", {7'h0, overrun_o}, 8'h00);
    chk("rst_bus", bus_o, 8'h00);
    rst_n = 1'b1;

    // 1: scan order, no keys
    for (int i = 0; i < 32; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      chk("scan_col", {4'h0, col_o}, {4'h0, exp_col});
      tick(1);
    end
    chk("idle_valid", {7'h0, key_valid_o}, 8'h00);
    chk("idle_bus", bus_o, 8'h00);

    // 2: key 6 (row1,col2) held 4 frames
    pressed = 16'h0040;
    tick(32);
    chk("k6_latency", {7'h0, key_valid_o}, 8'h00);
    tick(1);
    chk("k6_valid", {7'h0, key_valid_o}, 8'h01);
    chk("k6_key", {4'h0, key_o}, 8'h06);
    chk("k6_bus", bus_o, 8'h06);
    tick(31);
    chk("k6_held_once_bus", bus_o, 8'h06);
    chk("k6_held_no_overrun", {7'h0, overrun_o}, 8'h00);
    pressed = 16'h0;
    tick(32);
    ack_i = 1'b1; tick(1); ack_i = 1'b0;
    chk("k6_ack", {7'h0, key_valid_o}, 8'h00);
    tick(15);

    // 3: keys A then B without ack
    pressed = 16'h0400;  // row2,col2
    tick(48);
    pressed = 16'h0;
    tick(32);
    chk("kA_key", {4'h0, key_o}, 8'h0A);
    chk("kA_bus", bus_o, 8'h6A);
    pressed = 16'h0800;  // row2,col3
    tick(48);
    pressed = 16'h0;
    tick(32);
    chk("kB_bus", bus_o, 8'hAB);
    chk("kB_key_kept", {4'h0, key_o}, 8'h0A);
    chk("kB_overrun", {7'h0, overrun_o}, 8'h01);
    ack_i = 1'b1; tick(1); ack_i = 1'b0;
    chk("kB_ack_valid", {7'h0, key_valid_o}, 8'h00);
    chk("kB_ack_overrun", {7'h0, overrun_o}, 8'h00);
    clear_i = 1'b1; tick(1); clear_i = 1'b0;
    chk("clear_bus", bus_o, 8'h00);
    tick(14);

    // 4: key 3 (row0,col3) bouncing frame by frame
    for (int f = 0; f < 6; f++) begin
      pressed = (f % 2 == 0) ? 16'h0008 : 16'h0;
      tick(16);
    end
    pressed = 16'h0;
    chk("bounce_valid", {7'h0, key_valid_o}, 8'h00);
    chk("bounce_bus", bus_o, 8'h00);

    // 5: keys 0 and 5 together, then 5 released
    pressed = 16'h0021;
    tick(64);
    chk("multi_valid", {7'h0, key_valid_o}, 8'h00);
    chk("multi_bus", bus_o, 8'h00);
    pressed = 16'h0001;
    tick(32);
    chk("k0_latency", {7'h0, key_valid_o}, 8'h00);
    tick(1);
    chk("k0_valid", {7'h0, key_valid_o}, 8'h01);
    chk("k0_key", {4'h0, key_o}, 8'h00);
    tick(15);
    ack_i = 1'b1; tick(1); ack_i = 1'b0;
    pressed = 16'h0;
    tick(47);

    // 6: reset between first and second qualifying frames of key F
    pressed = 16'h8000;  // row3,col3
    tick(16);
    tick(6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", {4'h0, col_o}, 8'h0E);
    chk("mid_rst_valid", {7'h0, key_valid_o}, 8'h00);
    chk("mid_rst_key", {4'h0, key_o}, 8'h00);
    chk("mid_rst_bus", bus_o, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(16);
    chk("kF_frame1", {7'h0, key_valid_o}, 8'h00);
    tick(16);
    chk("kF_latency", {7'h0, key_valid_o}, 8'h00);
    tick(1);
    chk("kF_valid", {7'h0, key_valid_o}, 8'h01);
    chk("kF_key", {4'h0, key_o}, 8'h0F);
    chk("kF_bus", bus_o, 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
